// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM states, addressing-mode
// encodings, the zero-extend control bit, and small decode helpers.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  localparam logic [1:0] MODE_BYTE = 2'b00;
  localparam logic [1:0] MODE_HALF = 2'b01;
  localparam logic [1:0] MODE_WORD = 2'b10;
  localparam logic [1:0] MODE_ILL  = 2'b11;

  localparam int CTRL_ZEXT = 2;

  // Captured command fields that do not scale with DATA_WIDTH
  typedef struct packed {
    logic       we;
    logic [2:0] ctrl;
  } lsu_cmd_t;

  // Index of the final byte of an access (byte count minus one)
  function automatic logic [1:0] last_byte(input logic [1:0] mode);
    case (mode)
      MODE_BYTE: last_byte = 2'd0;
      MODE_HALF: last_byte = 2'd1;
      default:   last_byte = 2'd3;
    endcase
  endfunction

  // Natural-alignment check on the low address bits
  function automatic logic misaligned(input logic [1:0] mode, input logic [1:0] alo);
    case (mode)
      MODE_HALF: misaligned = alo[0];
      MODE_WORD: misaligned = (alo != 2'b00);
      default:   misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// Sign/zero extension of the assembled load result. Word results pass
// through untouched; the zero-extend bit only matters for byte and half.
module lsu_extend
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]            mode,
  input  logic                  zext,
  input  logic [DATA_WIDTH-1:0] raw,
  output logic [DATA_WIDTH-1:0] ext
);

  // Replicate either zero or the top data bit of the access width
  always_comb begin
    ext = raw;
    case (mode)
      MODE_BYTE: ext = zext ? {{(DATA_WIDTH-8){1'b0}}, raw[7:0]}
                            : {{(DATA_WIDTH-8){raw[7]}}, raw[7:0]};
      MODE_HALF: ext = zext ? {{(DATA_WIDTH-16){1'b0}}, raw[15:0]}
                            : {{(DATA_WIDTH-16){raw[15]}}, raw[15:0]};
      default:   ext = raw;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte-serial load/store unit: one request at a time, moved through a
// byte-wide memory one byte per cycle, then a single-cycle response.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned half/word requests
// are rejected with resp_err instead of being executed byte-serially.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_ctrl,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata
);

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] XFER = ST_XFER;
  localparam logic [1:0] RESP = ST_RESP;

  logic [1:0]            state;
  lsu_cmd_t              cmd;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic [DATA_WIDTH-1:0] ext_data;
  logic [1:0]            cnt;
  logic                  err_q;
  logic                  trap;
  logic                  xfer;

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = (req_ctrl[1:0] == MODE_ILL) || misaligned(req_ctrl[1:0], req_addr[1:0]);
`else
  assign trap = (req_ctrl[1:0] == MODE_ILL);
`endif

  // Request capture, byte sequencing and load assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 2'd0;
      result_q <= '0;
      cmd      <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cmd      <= '{we: req_we, ctrl: req_ctrl};
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            cnt      <= 2'd0;
            result_q <= '0;
            err_q    <= trap;
            state    <= trap ? RESP : XFER;
          end
        end
        XFER: begin
          if (!cmd.we) result_q[{cnt, 3'b000} +: 8] <= mem_rdata;
          if (cnt == last_byte(cmd.ctrl[1:0])) state <= RESP;
          else                                 cnt   <= cnt + 2'd1;
        end
        RESP: begin
          state <= IDLE;
          cnt   <= 2'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign xfer = (state == XFER);

  // Memory port is quiet outside XFER; a reset arriving mid-store masks the
  // write strobe so the byte in flight at that edge never lands.
  assign mem_addr  = xfer ? addr_q + DATA_WIDTH'(cnt) : '0;
  assign mem_we    = xfer & cmd.we & ~rst;
  assign mem_wdata = xfer ? wdata_q[{cnt, 3'b000} +: 8] : 8'h00;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_err   = resp_valid & err_q;
  assign resp_rdata = (resp_valid && !err_q && !cmd.we) ? ext_data : '0;

  lsu_extend #(.DATA_WIDTH(DATA_WIDTH)) u_ext (
    .mode (cmd.ctrl[1:0]),
    .zext (cmd.ctrl[CTRL_ZEXT]),
    .raw  (result_q),
    .ext  (ext_data)
  );

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the request address and data width.
REQ-002 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1, SHALL be the reset: synchronous, active-high.
REQ-004 Port req_valid, input, 1, SHALL mark a pipeline memory request.
REQ-005 Port req_ready, output, 1, SHALL mark the unit able to accept a request.
REQ-006 Port req_we, input, 1, SHALL select store (1) or load (0).
REQ-007 Port req_ctrl, input, 3, SHALL carry the addressing control: [1:0] 00 byte, 01 half, 10 word, 11 illegal; [2] zero-extend.
REQ-008 Port req_addr, input, DATA_WIDTH, SHALL carry the byte address.
REQ-009 Port req_wdata, input, DATA_WIDTH, SHALL carry the store data, right-aligned.
REQ-010 Port resp_valid, output, 1, SHALL pulse for one cycle per completed request.
REQ-011 Port resp_rdata, output, DATA_WIDTH, SHALL carry the extended load result.
REQ-012 Port resp_err, output, 1, SHALL flag a rejected request, qualified by resp_valid.
REQ-013 Port mem_addr, output, DATA_WIDTH, SHALL carry the byte address to the byte-wide data memory.
REQ-014 Port mem_we, output, 1, SHALL carry the byte write enable.
REQ-015 Port mem_wdata, output, 8, SHALL carry the byte write data.
REQ-016 Port mem_rdata, input, 8, SHALL carry the combinational byte read data for mem_addr in the same cycle.

Function
REQ-017 States SHALL be IDLE, XFER, RESP; req_ready SHALL be 1 only in IDLE.
REQ-018 Accept SHALL occur on a rising edge with req_valid && req_ready; all req_* fields captured then, later input changes ignored.
REQ-019 Accept SHALL move IDLE->XFER with byte count N = 1/2/4 for ctrl 00/01/10 and counter = 0.
REQ-020 In XFER, each cycle SHALL drive one byte: mem_addr = captured addr + counter (modulo 2^DATA_WIDTH wrap), mem_we = captured we.
REQ-021 In store XFER cycles, mem_wdata SHALL be wdata byte [8*counter+7 : 8*counter]; in loads, mem_rdata SHALL be stored into result byte lane counter.
REQ-022 After XFER byte N-1, the state SHALL go to RESP; resp_valid = 1 for exactly that one cycle, then IDLE.
REQ-023 Latency: accept at edge k -> XFER cycles k+1..k+N, resp_valid in cycle k+N+1, req_ready again in cycle k+N+2.
REQ-024 Load result: byte/half SHALL be sign-extended from bit 7/15 when ctrl[2] = 0, zero-extended when ctrl[2] = 1; for word, ctrl[2] SHALL be ignored.
REQ-025 resp_rdata SHALL be 0 for stores and errors, and whenever resp_valid = 0.
REQ-026 ctrl[1:0] = 11 SHALL perform no memory cycle, going IDLE->RESP with resp_err = 1.
REQ-027 Outside XFER, mem_we SHALL be 0 and mem_addr/mem_wdata SHALL be 0.

Reset
REQ-028 rst SHALL force IDLE, counter 0, result 0; outputs after the edge: req_ready = 1, resp_valid = 0, resp_err = 0, mem_we = 0.
REQ-029 rst mid-XFER SHALL abandon the request: no further memory byte is written, and no response is produced.
REQ-030 rst SHALL take priority over a simultaneous accept.

Configuration
REQ-031 Macro LSU_MISALIGN_TRAP_EN defined: half with addr[0] != 0, or word with addr[1:0] != 0, SHALL skip XFER, go to RESP with resp_err = 1, and perform no memory cycle.
REQ-032 Macro LSU_MISALIGN_TRAP_EN undefined: misaligned accesses SHALL execute byte-serially as aligned ones; resp_err is set only per REQ-026.

Structure
REQ-033 Package lsu_pkg SHALL hold the state enum, the addressing-mode encodings (BYTE = 00, HALF = 01, WORD = 10), and the ZEXT bit index 2.
REQ-034 One sub-module, lsu_extend, SHALL perform the combinational sign/zero extension of the assembled result.

Verification
REQ-035 Word load, addr 0x10000, memory bytes 78 56 34 12 -> resp_rdata 0x12345678 in cycle k+5, resp_err 0.
REQ-036 lb then lbu from a byte 0x80 -> 0xFFFFFF80 then 0x00000080; lh of bytes 00 80 -> 0xFFFF8000.
REQ-037 sw 0xDEADBEEF to 0x10004 -> mem writes EF, BE, AD, DE at 0x10004..0x10007 on consecutive cycles, then resp_valid with rdata 0.
REQ-038 ctrl = 011 -> no mem_we, resp_valid in cycle k+1, resp_err 1; sh to 0x10001 -> resp_err 1 with the macro, two writes without it.
REQ-039 rst asserted in the 2nd XFER cycle of sw -> only the first byte is written, no resp_valid, req_ready = 1 next cycle.
REQ-040 Word load at 0xFFFFFFFE -> mem_addr sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001 (macro undefined).
